// File: rtl/t08_mem_pkg.sv
// Shared types and constants for the t08 memory handler / Wishbone bridge pair.
package t08_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUS, DONE} bridge_state_t;

  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } size_t;

  // Control fields of an accepted access, held for the whole bus cycle
  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [1:0] k;
  } req_ctl_t;

  localparam logic [31:0] I2C_ADDRESS = 32'h0000_8000;

endpackage

// File: rtl/t08_mem_bridge_if.sv
// Wishbone-classic link between the bridge (master) and the interconnect (slave).
interface t08_mem_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/t08_lane_align.sv
// Byte-lane steering: select/write-data placement, read extraction with extension,
// and alignment check, all from the low address bits and func3 size.
module t08_lane_align
  import t08_mem_pkg::*;
(
  input  logic [1:0]  k,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdat,
  output logic        misalign
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] rb;
  logic [NUM_LANES-1:0]      bsel;
  logic [7:0]                byte_l;
  logic [15:0]               half_l;

  assign rb = bus_rdata;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign bsel[i] = (k == i[1:0]);
    end
  endgenerate

  assign byte_l = rb[k];
  assign half_l = k[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    sel      = 4'b1111;
    wdat     = wdata;
    rdat     = bus_rdata;
    misalign = (k != 2'b00);
    case (size)
      SZ_B, SZ_BU: begin
        sel      = bsel;
        wdat     = {4{wdata[7:0]}};
        rdat     = (size == SZ_B) ? {{24{byte_l[7]}}, byte_l} : {24'd0, byte_l};
        misalign = 1'b0;
      end
      SZ_H, SZ_HU: begin
        sel      = k[1] ? 4'b1100 : 4'b0011;
        wdat     = {2{wdata[15:0]}};
        rdat     = (size == SZ_H) ? {{16{half_l[15]}}, half_l} : {16'd0, half_l};
        misalign = k[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/t08_mem_bridge.sv
// Converts single-cycle handler read/write requests into Wishbone-classic cycles,
// returning aligned read data with done/err pulses and an ack timeout.
module t08_mem_bridge
  import t08_mem_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  size_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  t08_mem_bridge_if.master wb
);
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

  bridge_state_t state;
  req_ctl_t      ctl_q;
  logic [15:0]   tcnt;
  logic          cyc_q, stb_q, we_q;
  logic [31:0]   adr_q, dat_q;
  logic [3:0]    sel_q;

  logic [1:0]  a_k;
  logic [2:0]  a_size;
  logic [3:0]  a_sel;
  logic [31:0] a_wdat, a_rdat;
  logic        a_mis;

  // The aligner looks at the incoming request while idle (placement and alignment
  // check) and at the held access during the bus cycle (read extraction).
  assign a_k    = (state == IDLE) ? addr_i[1:0] : ctl_q.k;
  assign a_size = (state == IDLE) ? size_i      : ctl_q.size;

  t08_lane_align u_align (
    .k         (a_k),
    .size      (a_size),
    .wdata     (wdata_i),
    .bus_rdata (wb.wb_dat_i),
    .sel       (a_sel),
    .wdat      (a_wdat),
    .rdat      (a_rdat),
    .misalign  (a_mis)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ctl_q   <= '0;
      tcnt    <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            ctl_q <= '{we: write_i, size: size_i, k: addr_i[1:0]};
            if (a_mis) begin
              state  <= DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state  <= BUS;
              cyc_q  <= 1'b1;
              stb_q  <= 1'b1;
              busy_o <= 1'b1;
              we_q   <= write_i;
              adr_q  <= {addr_i[31:2], 2'b00};
              dat_q  <= a_wdat;
              sel_q  <= a_sel;
              tcnt   <= '0;
            end
          end
        end
        BUS: begin
          if (wb.wb_err_i || wb.wb_ack_i || tcnt == TLIM) begin
            state  <= DONE;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            // err beats ack; a timeout is reported like a bus error
            if (wb.wb_err_i || !wb.wb_ack_i) begin
              err_o <= 1'b1;
              if (!ctl_q.we) rdata_o <= ERR_RDATA;
            end else if (!ctl_q.we) begin
              rdata_o <= a_rdat;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
endmodule
